// File: rtl/dbus_gpio_timer_if.sv
// Data-bus slave port bundle for dbus_gpio_timer.
//   din  : write data from the bus master
//   addr : word address (block select is decoded upstream)
//   we   : write enable, already qualified by the block select
//   dout : registered read data, valid one cycle after addr
// master modport drives din/addr/we; slave modport drives dout.
interface dbus_gpio_timer_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic [DW-1:0] din;
  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] dout;

  modport master (output din, output addr, output we, input dout);
  modport slave  (input din, input addr, input we, output dout);
endinterface

// File: rtl/dbus_gpio_timer.sv
// Memory-mapped GPIO + 16-bit style timer peripheral on the processor data bus.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of dbus_gpio_timer_if (din/addr/we in, dout out)
//   gpio_in  : asynchronous external inputs (two-flop synchronized)
//   gpio_out : GPIO_OUT register contents
//   irq      : MATCH & IRQ_EN, straight from flops
// Register offsets (addr[2:0]): 0 GPIO_OUT, 1 GPIO_IN (RO), 2 CTRL
// {IRQ_EN,AUTO_RELOAD,EN}, 3 TMR_CMP, 4 TMR_CNT, 5 STAT (MATCH, W1C),
// 6 PRESC, 7 reserved. Reads are registered and see pre-write state.
module dbus_gpio_timer #(
  parameter int            DW      = 16,
  parameter int            AW      = 16,
  parameter logic [DW-1:0] CMP_RST = DW'(16'hFFFF)
)(
  input  logic          clk,
  input  logic          rst,
  dbus_gpio_timer_if.slave bus,
  input  logic [DW-1:0] gpio_in,
  output logic [DW-1:0] gpio_out,
  output logic          irq
);
  localparam logic [2:0] OFF_GPO  = 3'd0;
  localparam logic [2:0] OFF_GPI  = 3'd1;
  localparam logic [2:0] OFF_CTRL = 3'd2;
  localparam logic [2:0] OFF_CMP  = 3'd3;
  localparam logic [2:0] OFF_CNT  = 3'd4;
  localparam logic [2:0] OFF_STAT = 3'd5;
  localparam logic [2:0] OFF_PRSC = 3'd6;

  logic [DW-1:0] gpo, sync1, sync2, cmp, cnt, presc, pcnt, rdata;
  logic          en, auto_rl, irq_en, match;
  logic [2:0]    off;
  logic          wr_gpo, wr_ctrl, wr_cmp, wr_cnt, wr_stat, wr_prsc;
  logic          tick, hit;
  logic          unused_addr;

  assign off         = bus.addr[2:0];
  assign unused_addr = ^bus.addr[AW-1:3];

  assign wr_gpo  = bus.we && (off == OFF_GPO);
  assign wr_ctrl = bus.we && (off == OFF_CTRL);
  assign wr_cmp  = bus.we && (off == OFF_CMP);
  assign wr_cnt  = bus.we && (off == OFF_CNT);
  assign wr_stat = bus.we && (off == OFF_STAT);
  assign wr_prsc = bus.we && (off == OFF_PRSC);

  assign tick = en && (pcnt == presc);
  assign hit  = tick && (cnt == cmp);

  assign gpio_out = gpo;
  assign irq      = match & irq_en;

  // GPIO output, input synchronizer, compare and prescale registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gpo   <= '0;
      sync1 <= '0;
      sync2 <= '0;
      cmp   <= CMP_RST;
      presc <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      if (wr_gpo)  gpo   <= bus.din;
      if (wr_cmp)  cmp   <= bus.din;
      if (wr_prsc) presc <= bus.din;
    end
  end

  // Prescaler. A PRESC write does not touch pcnt; if pcnt is already past
  // the new limit it runs up through the 2^DW wrap before matching again.
  always_ff @(posedge clk) begin
    if (rst)                       pcnt <= '0;
    else if (wr_ctrl && !bus.din[0]) pcnt <= '0;
    else if (!en || tick)          pcnt <= '0;
    else                           pcnt <= pcnt + DW'(1);
  end

  // Timer control, counter and sticky match.
  // Bus writes beat the tick update for CNT and the one-shot EN clear;
  // a match set beats a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      en      <= 1'b0;
      auto_rl <= 1'b0;
      irq_en  <= 1'b0;
      cnt     <= '0;
      match   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en      <= bus.din[0];
        auto_rl <= bus.din[1];
        irq_en  <= bus.din[2];
      end else if (hit && !auto_rl) begin
        en <= 1'b0;
      end

      if (wr_cnt)                cnt <= bus.din;
      else if (hit && auto_rl)   cnt <= '0;
      else if (tick && !hit)     cnt <= cnt + DW'(1);

      if (hit)                          match <= 1'b1;
      else if (wr_stat && bus.din[0])   match <= 1'b0;
    end
  end

  // Read mux; registered below so dout carries pre-write values.
  always_comb begin
    rdata = '0;
    case (off)
      OFF_GPO:  rdata = gpo;
      OFF_GPI:  rdata = sync2;
      OFF_CTRL: rdata[2:0] = {irq_en, auto_rl, en};
      OFF_CMP:  rdata = cmp;
      OFF_CNT:  rdata = cnt;
      OFF_STAT: rdata[0] = match;
      OFF_PRSC: rdata = presc;
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) bus.dout <= '0;
    else     bus.dout <= rdata;
  end
endmodule
